// File: rtl/conv_pkg.sv
// Shared helpers for the streaming 2D convolution engine: config address map,
// output saturation and per-frame output count.
package conv_pkg;

  // Decoded target of a config write.
  typedef enum logic [1:0] {
    CfgNone,
    CfgWgt,
    CfgBias
  } cfg_sel_e;

  // Working width for the saturation helper; accumulators are sign-extended into it.
  localparam int unsigned SatW = 64;

  // Number of valid (unpadded) output positions in one frame.
  function automatic int unsigned out_per_frame(input int unsigned img_w,
                                                input int unsigned img_h,
                                                input int unsigned kernel);
    return (img_h - kernel + 1) * (img_w - kernel + 1);
  endfunction

  // Output count for the default frame geometry (32x8, 3x3 kernel).
  localparam int unsigned DefOutPerFrame = out_per_frame(32, 8, 3);

  // Flat index of weight w[f][c][ky][kx].
  function automatic int unsigned wgt_addr(input int unsigned f,
                                           input int unsigned c,
                                           input int unsigned ky,
                                           input int unsigned kx,
                                           input int unsigned ch_in,
                                           input int unsigned kernel);
    return ((f * ch_in + c) * kernel + ky) * kernel + kx;
  endfunction

  // Config address of bias[f]; biases sit directly after all weights.
  function automatic int unsigned bias_addr(input int unsigned f,
                                            input int unsigned num_filters,
                                            input int unsigned ch_in,
                                            input int unsigned kernel);
    return num_filters * ch_in * kernel * kernel + f;
  endfunction

  // Clamp a signed value to the range of a signed out_w-bit number.
  function automatic logic signed [SatW-1:0] sat(input logic signed [SatW-1:0] acc,
                                                 input int unsigned out_w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end
    return acc;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Line buffer and window store for conv2d_stream. Holds KERNEL-1 previous rows
// plus KERNEL-1 window columns, and presents the full KxK window whose
// bottom-right element is the pixel currently on pix_i. Everything shifts only
// when shift_i is high. Contents carry no reset; the counters in the parent
// guarantee no window is used before it is filled with current-frame rows.
module conv_line_buffer #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned KERNEL = 3,
  parameter int unsigned PIX_W  = 8
) (
  input  logic                             clk_i,
  input  logic                             shift_i,
  input  logic [PIX_W-1:0]                 pix_i,
  // Element (ky, kx) at [(ky*KERNEL+kx)*PIX_W +: PIX_W]; (KERNEL-1, KERNEL-1) is pix_i.
  output logic [KERNEL*KERNEL*PIX_W-1:0]   win_o
);

  if (KERNEL > 1) begin : g_buf
    // line_q[j] delays the stream by (j+1) rows.
    logic [PIX_W-1:0] line_q [KERNEL-1][IMG_W];
    // win_q[ky][kx] holds window columns 0..KERNEL-2 from earlier accepts.
    logic [PIX_W-1:0] win_q  [KERNEL][KERNEL-1];
    logic [PIX_W-1:0] col    [KERNEL];

    // Newest window column: row taps from the line buffers plus the live pixel.
    always_comb begin
      col[KERNEL-1] = pix_i;
      for (int j = 0; j < int'(KERNEL) - 1; j++) begin
        col[KERNEL-2-j] = line_q[j][IMG_W-1];
      end
    end

    // Row delay lines chained end to end, and the window column shift.
    always_ff @(posedge clk_i) begin
      if (shift_i) begin
        line_q[0][0] <= pix_i;
        for (int j = 1; j < int'(KERNEL) - 1; j++) begin
          line_q[j][0] <= line_q[j-1][IMG_W-1];
        end
        for (int j = 0; j < int'(KERNEL) - 1; j++) begin
          for (int i = 1; i < int'(IMG_W); i++) begin
            line_q[j][i] <= line_q[j][i-1];
          end
        end
        for (int ky = 0; ky < int'(KERNEL); ky++) begin
          for (int kx = 0; kx < int'(KERNEL) - 2; kx++) begin
            win_q[ky][kx] <= win_q[ky][kx+1];
          end
          win_q[ky][KERNEL-2] <= col[ky];
        end
      end
    end

    // Assemble the flat window: stored columns then the live column.
    always_comb begin
      win_o = '0;
      for (int ky = 0; ky < int'(KERNEL); ky++) begin
        for (int kx = 0; kx < int'(KERNEL) - 1; kx++) begin
          win_o[(ky*KERNEL+kx)*PIX_W +: PIX_W] = win_q[ky][kx];
        end
        win_o[(ky*KERNEL+KERNEL-1)*PIX_W +: PIX_W] = col[ky];
      end
    end
  end else begin : g_pass
    // A 1x1 kernel needs no history at all.
    assign win_o = pix_i;
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 2D convolution, one pixel per handshake in raster order, producing
// NUM_FILTERS results per unpadded window position. Weights/biases are written
// through the cfg port. Optional macro CONV2D_STREAM_RELU_EN clamps negative
// saturated results to zero.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W       = 32,
  parameter int unsigned IMG_H       = 8,
  parameter int unsigned CH_IN       = 1,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned KERNEL      = 3,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WGT_W       = 8,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned OUT_SHIFT   = 4,
  localparam int unsigned NumCfg     = NUM_FILTERS * (CH_IN * KERNEL * KERNEL + 1),
  localparam int unsigned AddrW      = (NumCfg > 1) ? $clog2(NumCfg) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CH_IN*DATA_W-1:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_FILTERS*OUT_W-1:0]  out_data,
  output logic                          out_last,
  input  logic                          cfg_we,
  input  logic [AddrW-1:0]              cfg_addr,
  input  logic [WGT_W-1:0]              cfg_data
);

  localparam int unsigned PixW     = CH_IN * DATA_W;
  localparam int unsigned NumW     = NUM_FILTERS * CH_IN * KERNEL * KERNEL;
  localparam int unsigned BiasBase = bias_addr(0, NUM_FILTERS, CH_IN, KERNEL);
  localparam int unsigned ColW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WidxW    = (NumW > 1) ? $clog2(NumW) : 1;
  localparam int unsigned BidxW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic [ColW-1:0]                 col_q, col_d;
  logic [RowW-1:0]                 row_q, row_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;
  logic [NUM_FILTERS*OUT_W-1:0]    out_data_q, out_data_d;
  logic signed [WGT_W-1:0]         wgt_q  [NumW];
  logic signed [WGT_W-1:0]         bias_q [NUM_FILTERS];

  logic                            accept;
  logic                            col_last, row_last, win_hit;
  logic [KERNEL*KERNEL*PixW-1:0]   win;
  logic [NUM_FILTERS*OUT_W-1:0]    result;
  cfg_sel_e                        cfg_sel;
  logic [WidxW-1:0]                widx;
  logic [BidxW-1:0]                bidx;

  // Whole datapath advances only when the output register can take a new value.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign col_last = (col_q == ColW'(IMG_W - 1));
  assign row_last = (row_q == RowW'(IMG_H - 1));
  assign win_hit  = (row_q >= RowW'(KERNEL - 1)) && (col_q >= ColW'(KERNEL - 1));

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  conv_line_buffer #(
    .IMG_W  (IMG_W),
    .KERNEL (KERNEL),
    .PIX_W  (PixW)
  ) u_line_buffer (
    .clk_i   (clk),
    .shift_i (accept),
    .pix_i   (in_data),
    .win_o   (win)
  );

  // Raster position of the pixel on in_data; wraps into the next frame with no gap.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Multiply-accumulate, shift, saturate (and optionally rectify) every filter.
  always_comb begin
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [SatW-1:0]   satv;
    logic signed [DATA_W-1:0] xs;
    logic signed [WGT_W-1:0]  ws;
    result  = '0;
    acc     = '0;
    shifted = '0;
    satv    = '0;
    xs      = '0;
    ws      = '0;
    for (int f = 0; f < int'(NUM_FILTERS); f++) begin
      acc = ACC_W'(bias_q[f]);
      for (int c = 0; c < int'(CH_IN); c++) begin
        for (int ky = 0; ky < int'(KERNEL); ky++) begin
          for (int kx = 0; kx < int'(KERNEL); kx++) begin
            xs  = $signed(win[(ky*KERNEL+kx)*PixW + c*DATA_W +: DATA_W]);
            ws  = wgt_q[wgt_addr(f, c, ky, kx, CH_IN, KERNEL)];
            acc = acc + ACC_W'(ws) * ACC_W'(xs);
          end
        end
      end
      // >>> on a signed value floors toward -inf.
      shifted = acc >>> OUT_SHIFT;
      satv    = sat(SatW'(shifted), OUT_W);
`ifdef CONV2D_STREAM_RELU_EN
      if (satv < 0) begin
        satv = '0;
      end
`endif
      result[f*OUT_W +: OUT_W] = OUT_W'(satv);
    end
  end

  // Output register: load on a window, drop on a non-window accept or a bare drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (accept) begin
      if (win_hit) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
        out_last_d  = row_last && col_last;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Position counters and output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Config address decode; addresses past the last bias are dropped.
  always_comb begin
    cfg_sel = CfgNone;
    widx    = WidxW'(cfg_addr);
    bidx    = BidxW'(cfg_addr - AddrW'(BiasBase));
    if (cfg_we) begin
      if (32'(cfg_addr) < NumW) begin
        cfg_sel = CfgWgt;
      end else if (32'(cfg_addr) < NumCfg) begin
        cfg_sel = CfgBias;
      end
    end
  end

  // Weight and bias storage; takes effect for windows computed on later cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NumW); i++) begin
        wgt_q[i] <= '0;
      end
      for (int i = 0; i < int'(NUM_FILTERS); i++) begin
        bias_q[i] <= '0;
      end
    end else begin
      case (cfg_sel)
        CfgWgt:  wgt_q[widx]  <= cfg_data;
        CfgBias: bias_q[bidx] <= cfg_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Scoreboard bench for conv2d_stream on a 5x4 frame with a 3x3 kernel and a
// shift of 4. Expected results are queued as stimulus is issued; a monitor pops
// and compares on every output handshake.
module tb_conv2d_stream;

  localparam int unsigned IMG_W = 5;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned CH_IN = 1;
  localparam int unsigned NF    = 4;
  localparam int unsigned K     = 3;
  localparam int unsigned AW    = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_data;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   n_last = 0;

  // Hand-computed results for the "A" config (f0 centre 16, f1 centre -1,
  // f2 centre 1, f3 all ones) on frames with pixel = base + row*5 + col.
  int a_f0[6] = '{6, 7, 8, 11, 12, 13};
  int a_f3[6] = '{3, 3, 4, 6, 6, 7};
  int b_f0[6] = '{56, 57, 58, 61, 62, 63};
  int b_f3[6] = '{31, 32, 32, 34, 34, 35};

  conv2d_stream #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .CH_IN       (CH_IN),
    .NUM_FILTERS (NF),
    .KERNEL      (K),
    .DATA_W      (8),
    .WGT_W       (8),
    .ACC_W       (24),
    .OUT_W       (8),
    .OUT_SHIFT   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rl(input int v);
`ifdef CONV2D_STREAM_RELU_EN
    if (v < 0) v = 0;
`endif
    return 8'(v);
  endfunction

  function automatic logic [31:0] pk(input int f0, input int f1, input int f2, input int f3);
    return {rl(f3), rl(f2), rl(f1), rl(f0)};
  endfunction

  task automatic push(input logic [31:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int r = 0; r < int'(IMG_H); r++)
      for (int c = 0; c < int'(IMG_W); c++) send(8'(base + r * 5 + c));
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = 8'(d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Weights all set to w, biases zeroed.
  task automatic cfg_fill(input int w);
    for (int a = 0; a < 36; a++) cfg_write(a, w);
    for (int f = 0; f < 4; f++) cfg_write(36 + f, 0);
  endtask

  task automatic cfg_a();
    cfg_fill(0);
    cfg_write(0 * 9 + 4, 16);
    cfg_write(1 * 9 + 4, -1);
    cfg_write(2 * 9 + 4, 1);
    for (int a = 27; a < 36; a++) cfg_write(a, 1);
    cfg_write(63, 8'h55);  // out of range, must be ignored
  endtask

  task automatic push_frame_a();
    for (int i = 0; i < 6; i++) push(pk(a_f0[i], -1, 0, a_f3[i]), i == 5);
  endtask

  task automatic push_frame_b();
    for (int i = 0; i < 6; i++) push(pk(b_f0[i], -4, 3, b_f3[i]), i == 5);
  endtask

  task automatic push_same(input logic [31:0] d);
    for (int i = 0; i < 6; i++) push(d, i == 5);
  endtask

  // Wait (bounded) for every queued result to be consumed, then check counts.
  task automatic drain(input string name, input int outs, input int lasts, input int o0,
                       input int l0);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_count"}, n_out - o0, outs);
    chk({name, "_lasts"}, n_last - l0, lasts);
  endtask

  // Scoreboard monitor: compare on every output handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (out_last) n_last++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_extra: got data %h last %b required no output", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          errors++;
          $display("FAIL out_%0d: got data %h last %b required data %h last %b",
                   n_out, out_data, out_last, e.data, e.last);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int o0;
    int l0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Centre-tap / window-sum frame.
    cfg_a();
    o0 = n_out; l0 = n_last;
    push_frame_a();
    send_frame(0);
    drain("ident", 6, 1, o0, l0);

    // Backpressure on the first output of a frame.
    o0 = n_out; l0 = n_last;
    push_frame_a();
    for (int p = 0; p <= 12; p++) send(8'(p));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd13;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", out_data, pk(6, -1, 0, 3));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    for (int p = 13; p < 20; p++) send(8'(p));
    drain("bp", 6, 1, o0, l0);

    // Positive saturation.
    cfg_fill(127);
    o0 = n_out; l0 = n_last;
    push_same(pk(127, 127, 127, 127));
    for (int p = 0; p < 20; p++) send(8'd127);
    drain("sat_pos", 6, 1, o0, l0);

    // Negative saturation.
    cfg_fill(-128);
    o0 = n_out; l0 = n_last;
    push_same(pk(-128, -128, -128, -128));
    for (int p = 0; p < 20; p++) send(8'd127);
    drain("sat_neg", 6, 1, o0, l0);

    // Bias only, shifted by 4.
    cfg_fill(0);
    for (int f = 0; f < 4; f++) cfg_write(36 + f, f * 16 - 32);
    o0 = n_out; l0 = n_last;
    push_same(pk(-2, -1, 0, 1));
    send_frame(0);
    drain("bias", 6, 1, o0, l0);

    // Reset after 7 pixels, then a clean frame.
    for (int p = 0; p < 7; p++) send(8'(90 + p));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cfg_a();
    o0 = n_out; l0 = n_last;
    push_frame_a();
    send_frame(0);
    drain("midrst", 6, 1, o0, l0);

    // Two frames back to back with in_valid held high throughout.
    o0 = n_out; l0 = n_last;
    push_frame_a();
    push_frame_b();
    send_frame(0);
    send_frame(50);
    drain("b2b", 12, 2, o0, l0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
